// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and EX-side training bundle for the branch predictor.
// The statistics counters are carried here as well.
interface branch_predictor_if #(
    parameter int unsigned WORD = 32
);
    logic [WORD-1:0] IF_PC;
    logic            predict;
    logic [WORD-1:0] pred_PC;
    logic            upd_valid;
    logic [WORD-1:0] upd_PC;
    logic            upd_taken;
    logic [WORD-1:0] upd_target;
    logic            upd_mispredict;
    logic [31:0]     stat_branches;
    logic [31:0]     stat_mispred;

    modport master (
        output IF_PC, upd_valid, upd_PC, upd_taken, upd_target, upd_mispredict,
        input  predict, pred_PC, stat_branches, stat_mispred
    );

    modport slave (
        input  IF_PC, upd_valid, upd_PC, upd_taken, upd_target, upd_mispredict,
        output predict, pred_PC, stat_branches, stat_mispred
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters. Lookup on the fetch PC is
// combinational; training from EX is written at the clock edge.
module branch_predictor #(
    parameter int unsigned IDX_W = 6,
    parameter int unsigned WORD  = 32
) (
    input  logic               clk,
    input  logic               rst,
    branch_predictor_if.slave  bp
);
    localparam int unsigned ENTRIES = 2 ** IDX_W;
    localparam int unsigned TAG_W   = WORD - IDX_W - 2;

    logic             valid_q  [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [WORD-1:0]  target_q [ENTRIES];

    logic [31:0] stat_branches_q;
    logic [31:0] stat_mispred_q;

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic             lk_predict;

    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic [1:0]       up_ctr;
    logic [1:0]       ctr_nxt;
    logic             ctr_we;
    logic             tgt_we;

    logic unused_pc_lsb;
    assign unused_pc_lsb = ^bp.upd_PC[1:0];

    // Fetch-side lookup: the table is read as it stood before this cycle's update.
    always_comb begin
        lk_idx     = bp.IF_PC[IDX_W+1:2];
        lk_tag     = bp.IF_PC[WORD-1:IDX_W+2];
        lk_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        lk_predict = lk_hit && ctr_q[lk_idx][1];
    end

    assign bp.predict = lk_predict;
    assign bp.pred_PC = lk_predict ? target_q[lk_idx] : bp.IF_PC + WORD'(4);

    // Training decision; a miss that was taken allocates the entry weakly-taken.
    always_comb begin
        up_idx  = bp.upd_PC[IDX_W+1:2];
        up_tag  = bp.upd_PC[WORD-1:IDX_W+2];
        up_hit  = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        up_ctr  = ctr_q[up_idx];
        ctr_nxt = 2'b10;
        if (up_hit) begin
            if (bp.upd_taken) begin
                ctr_nxt = (up_ctr == 2'b11) ? 2'b11 : up_ctr + 2'd1;
            end else begin
                ctr_nxt = (up_ctr == 2'b00) ? 2'b00 : up_ctr - 2'd1;
            end
        end
        ctr_we = bp.upd_valid && (up_hit || bp.upd_taken);
        tgt_we = bp.upd_valid && bp.upd_taken;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (ctr_we) begin
            valid_q[up_idx] <= 1'b1;
            ctr_q[up_idx]   <= ctr_nxt;
        end
    end

    // Tag and target are only meaningful behind valid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (!rst && tgt_we) begin
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= bp.upd_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches_q <= 32'd0;
            stat_mispred_q  <= 32'd0;
        end else if (bp.upd_valid) begin
            stat_branches_q <= stat_branches_q + 32'd1;
            if (bp.upd_mispredict) begin
                stat_mispred_q <= stat_mispred_q + 32'd1;
            end
        end
    end

    assign bp.stat_branches = stat_branches_q;
    assign bp.stat_mispred  = stat_mispred_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a table-of-records model checked every
// cycle, plus hand-computed expectations at the interesting points.
module tb_branch_predictor;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_predictor_if #(.WORD(32)) bus ();

    branch_predictor #(.IDX_W(6), .WORD(32)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bus.slave)
    );

    int checks   = 0;
    int failures = 0;
    bit checking = 1'b0;

    // Reference model: one record per index, counter kept as a plain integer 0..3.
    bit          m_valid [64];
    int          m_ctr   [64];
    bit [23:0]   m_tag   [64];
    bit [31:0]   m_tgt   [64];
    bit [31:0]   m_br;
    bit [31:0]   m_mis;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                m_valid[i] = 1'b0;
                m_ctr[i]   = 1;
            end
            m_br  = 32'd0;
            m_mis = 32'd0;
        end else if (bus.upd_valid) begin
            int  i;
            bit  hit;
            m_br = m_br + 32'd1;
            if (bus.upd_mispredict) m_mis = m_mis + 32'd1;
            i   = int'(bus.upd_PC[7:2]);
            hit = m_valid[i] && (m_tag[i] == bus.upd_PC[31:8]);
            if (hit && bus.upd_taken) begin
                m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
                m_tgt[i] = bus.upd_target;
            end else if (hit) begin
                m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
            end else if (bus.upd_taken) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = bus.upd_PC[31:8];
                m_tgt[i]   = bus.upd_target;
                m_ctr[i]   = 2;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (checking) begin
            int         i;
            bit         exp_pred;
            bit [31:0]  exp_pc;
            i        = int'(bus.IF_PC[7:2]);
            exp_pred = m_valid[i] && (m_tag[i] == bus.IF_PC[31:8]) && (m_ctr[i] >= 2);
            exp_pc   = exp_pred ? m_tgt[i] : bus.IF_PC + 32'd4;
            chk("cyc_predict", {31'd0, bus.predict}, {31'd0, exp_pred});
            chk("cyc_pred_pc", bus.pred_PC, exp_pc);
            chk("cyc_stat_branches", bus.stat_branches, m_br);
            chk("cyc_stat_mispred", bus.stat_mispred, m_mis);
        end
    end

    task automatic apply(input bit r, input logic [31:0] pc, input bit uv,
                         input logic [31:0] upc, input bit ut,
                         input logic [31:0] utgt, input bit um);
        @(posedge clk);
        #1;
        rst                = r;
        bus.IF_PC          = pc;
        bus.upd_valid      = uv;
        bus.upd_PC         = upc;
        bus.upd_taken      = ut;
        bus.upd_target     = utgt;
        bus.upd_mispredict = um;
        @(negedge clk);
    endtask

    task automatic lookup(input logic [31:0] pc);
        apply(1'b0, pc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic lit(input string name, input bit exp_pred, input logic [31:0] exp_pc);
        chk({name, "_predict"}, {31'd0, bus.predict}, {31'd0, exp_pred});
        chk({name, "_pred_pc"}, bus.pred_PC, exp_pc);
    endtask

    localparam logic [31:0] PC_T  = 32'h1C00_0010;
    localparam logic [31:0] TG_T  = 32'h1C00_0100;
    localparam logic [31:0] PC_A  = 32'h1C00_1010;
    localparam logic [31:0] TG_A  = 32'h1C00_2000;
    localparam logic [31:0] PC_R  = 32'h1C00_3020;

    initial begin
        rst                = 1'b1;
        bus.IF_PC          = 32'h1C00_0000;
        bus.upd_valid      = 1'b0;
        bus.upd_PC         = 32'd0;
        bus.upd_taken      = 1'b0;
        bus.upd_target     = 32'd0;
        bus.upd_mispredict = 1'b0;

        apply(1'b1, 32'h1C00_0000, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        apply(1'b1, 32'h1C00_0000, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        checking = 1'b1;

        // Post-reset state
        lookup(32'h1C00_0000);
        lit("reset", 1'b0, 32'h1C00_0004);
        chk("reset_branches", bus.stat_branches, 32'd0);
        chk("reset_mispred", bus.stat_mispred, 32'd0);

        // Allocate; same-cycle lookup sees the old (empty) entry
        apply(1'b0, PC_T, 1'b1, PC_T, 1'b1, TG_T, 1'b0);
        lit("same_cycle_old", 1'b0, 32'h1C00_0014);
        lookup(PC_T);
        lit("alloc_hit", 1'b1, TG_T);
        chk("alloc_branches", bus.stat_branches, 32'd1);

        // Counter walk: each lookup shows the state before its own update
        apply(1'b0, PC_T, 1'b1, PC_T, 1'b0, 32'd0, 1'b1);
        lit("ctr10", 1'b1, TG_T);
        apply(1'b0, PC_T, 1'b1, PC_T, 1'b0, 32'd0, 1'b0);
        lit("ctr01", 1'b0, PC_T + 32'd4);
        apply(1'b0, PC_T, 1'b1, PC_T, 1'b0, 32'd0, 1'b0);
        lit("ctr00", 1'b0, PC_T + 32'd4);
        apply(1'b0, PC_T, 1'b1, PC_T, 1'b1, TG_T, 1'b1);
        lit("ctr00_sat", 1'b0, PC_T + 32'd4);
        apply(1'b0, PC_T, 1'b1, PC_T, 1'b1, TG_T, 1'b0);
        lit("ctr01_up", 1'b0, PC_T + 32'd4);
        apply(1'b0, PC_T, 1'b1, PC_T, 1'b1, TG_T, 1'b0);
        lit("ctr10_up", 1'b1, TG_T);
        apply(1'b0, PC_T, 1'b1, PC_T, 1'b1, TG_T, 1'b0);
        lit("ctr11", 1'b1, TG_T);
        apply(1'b0, PC_T, 1'b1, PC_T, 1'b0, 32'd0, 1'b0);
        lit("ctr11_sat", 1'b1, TG_T);
        lookup(PC_T);
        lit("ctr10_down", 1'b1, TG_T);
        chk("walk_branches", bus.stat_branches, 32'd9);
        chk("walk_mispred", bus.stat_mispred, 32'd2);

        // Aliasing on index 4
        apply(1'b0, PC_A, 1'b1, PC_A, 1'b1, TG_A, 1'b0);
        lit("alias_before", 1'b0, PC_A + 32'd4);
        lookup(PC_T);
        lit("alias_evicted", 1'b0, PC_T + 32'd4);
        lookup(PC_A);
        lit("alias_hit", 1'b1, TG_A);
        apply(1'b0, PC_A, 1'b1, PC_T, 1'b0, 32'd0, 1'b0);
        lookup(PC_A);
        lit("miss_nt_nochange", 1'b1, TG_A);

        // PC+4 wrap on an empty entry
        lookup(32'hFFFF_FFFC);
        lit("pc_wrap", 1'b0, 32'h0000_0000);

        // Mispredict without valid is ignored
        apply(1'b0, PC_T, 1'b0, PC_T, 1'b1, TG_T, 1'b1);
        lookup(PC_T);
        chk("noval_branches", bus.stat_branches, 32'd11);
        chk("noval_mispred", bus.stat_mispred, 32'd2);

        // Counter wrap via backdoor preload
        #1;
        force dut.stat_branches_q = 32'hFFFF_FFFE;
        force dut.stat_mispred_q  = 32'hFFFF_FFFF;
        #1;
        release dut.stat_branches_q;
        release dut.stat_mispred_q;
        m_br  = 32'hFFFF_FFFE;
        m_mis = 32'hFFFF_FFFF;
        apply(1'b0, PC_A, 1'b1, PC_A, 1'b1, TG_A, 1'b1);
        chk("preload_mispred", bus.stat_mispred, 32'hFFFF_FFFF);
        apply(1'b0, PC_A, 1'b1, PC_A, 1'b0, 32'd0, 1'b1);
        chk("wrap_mispred", bus.stat_mispred, 32'd0);
        chk("pre_wrap_branches", bus.stat_branches, 32'hFFFF_FFFF);
        lookup(PC_A);
        chk("wrap_branches", bus.stat_branches, 32'd0);
        chk("wrap_mispred2", bus.stat_mispred, 32'd1);
        lit("ctr_after_wrap", 1'b1, TG_A);

        // Reset coincident with an update drops the update
        apply(1'b1, PC_A, 1'b1, PC_R, 1'b1, 32'h1C00_4000, 1'b1);
        lookup(PC_R);
        lit("rst_upd_dropped", 1'b0, PC_R + 32'd4);
        chk("rst_upd_branches", bus.stat_branches, 32'd0);
        chk("rst_upd_mispred", bus.stat_mispred, 32'd0);
        lookup(PC_A);
        lit("rst_cleared", 1'b0, PC_A + 32'd4);

        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
